// File: rtl/sha_msg_sched_if.sv
// Handshake bundle between the SHA-256 message-schedule stage (master) and
// its consumer, the round stage (slave).
interface sha_msg_sched_if #(
   parameter int W_SIZE = 32
);
   logic                   start;
   logic [16*W_SIZE-1:0]   block;
   logic [W_SIZE-1:0]      w_out;
   logic [W_SIZE-1:0]      k_out;
   logic [5:0]             t_idx;
   logic                   w_valid;
   logic                   w_ready;
   logic                   busy;
   logic                   done;

   modport master (
      input  start, block, w_ready,
      output w_out, k_out, t_idx, w_valid, busy, done
   );

   modport slave (
      output start, block, w_ready,
      input  w_out, k_out, t_idx, w_valid, busy, done
   );
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: streams W[0..63] with K[t] over a valid/ready
// handshake, deriving W[16..63] from a 16-word sliding window.
module sha_msg_sched #(
   parameter int W_SIZE = 32,   // only 32 is meaningful (SHA-256)
   parameter int ROUNDS = 64    // only 64 is meaningful (SHA-256)
) (
   input  logic             clk,
   input  logic             reset,
   sha_msg_sched_if.master  bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [0:63][W_SIZE-1:0] K_ROM = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   logic [0:0]        state;
   logic [W_SIZE-1:0] win [16];
   logic [5:0]        t;
   logic              done_q;

   logic              running;
   logic              last;
   logic [W_SIZE-1:0] w_next;

   assign running = (state == ST_RUN);
   assign last    = (t == 6'(ROUNDS - 1));
   // Sums wrap at 32 bits; the carry out is simply dropped by the width.
   assign w_next  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         t      <= '0;
         done_q <= 1'b0;
         // NOTE: the window is reset (not left to power-up garbage) so w_out reads 0 and never carries X.
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < 16; i++) win[i] <= bus.block[(16-i)*W_SIZE-1 -: W_SIZE];
                  t     <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.w_ready) begin
                  // The last transfer also shifts; the leftover window is never observed.
                  for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                  win[15] <= w_next;
                  if (last) begin
                     state  <= ST_IDLE;
                     t      <= '0;
                     done_q <= 1'b1;
                  end else begin
                     t <= t + 6'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: outputs are gated by state in plain continuous assigns, so no latch and no stale K in IDLE.
   assign bus.w_valid = running;
   assign bus.busy    = running;
   assign bus.done    = done_q;
   assign bus.t_idx   = t;
   assign bus.w_out   = running ? win[0] : '0;
   assign bus.k_out   = running ? K_ROM[t] : '0;

endmodule
